ni_packet_if: RTL and testbench

Parametrised second-generation network interface between a core and a router port.
- TX path: buffers core payload words in a TX FIFO, then packetizes them into head/body/tail flits on a valid/ready link.
- RX path: depacketizes incoming flits, filters them by destination, and buffers payload in an RX FIFO.
- RX FIFO has a programmable-threshold interrupt and a drop counter.

---
 rtl/ni_packet_if.sv | 332 +++++++++++++++++++++++++++++++++
 tb/tb_ni_packet_if.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ni_packet_if.sv
// ni_packet_if: core-to-router network interface.
// TX packetizer and RX depacketizer with destination filter.

module ni_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push && (count != CNT_W'(DEPTH));
  assign pop_ok  = pop && (count != '0);
  assign dout    = mem[rd_ptr];

  // pointers wrap naturally; occupancy tracks push/pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop_ok)
        count <= count + CNT_W'(1);
      else if (!push_ok && pop_ok)
        count <= count - CNT_W'(1);
    end
  end

  // storage array, contents need no reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

module ni_packet_if #(
  parameter int DATA_W  = 32,
  parameter int ID_W    = 8,
  parameter int LEN_W   = 6,
  parameter int DEPTH   = 64,
  parameter int NODE_ID = 0,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] core_tx_data,
  input  logic              core_tx_wr_en,
  output logic              core_tx_full,
  input  logic [ID_W-1:0]   core_tx_dest,
  input  logic [LEN_W-1:0]  core_tx_len,
  input  logic              core_tx_start,
  output logic              core_tx_busy,
  output logic [DATA_W-1:0] core_rx_data,
  input  logic              core_rx_rd_en,
  output logic              core_rx_empty,
  output logic [CNT_W-1:0]  core_rx_count,
  input  logic [CNT_W-1:0]  rx_thresh_level,
  output logic              core_rx_thresh,
  output logic [15:0]       rx_drop_count,
  output logic [DATA_W+1:0] link_out_flit,
  output logic              link_out_valid,
  input  logic              link_out_ready,
  input  logic [DATA_W+1:0] link_in_flit,
  input  logic              link_in_valid,
  output logic              link_in_ready
);

  localparam logic [ID_W-1:0] NID = ID_W'(NODE_ID);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_HEAD,
    TX_BODY
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_WAIT,
    RX_ACCEPT,
    RX_DROP
  } rx_state_t;

  logic [DATA_W-1:0] tx_fifo_data;
  logic [CNT_W-1:0]  tx_count;
  logic              tx_empty;
  logic              tx_full;
  logic              tx_pop;

  logic [DATA_W-1:0] rx_fifo_data;
  logic [CNT_W-1:0]  rx_count;
  logic              rx_empty;
  logic              rx_full;
  logic              rx_push;

  tx_state_t         tx_state;
  tx_state_t         tx_state_n;
  logic [DATA_W+1:0] tx_flit;
  logic [DATA_W+1:0] tx_flit_n;
  logic              tx_valid;
  logic              tx_valid_n;
  logic [LEN_W-1:0]  tx_rem;
  logic [LEN_W-1:0]  tx_rem_n;
  logic              tx_busy;
  logic              tx_busy_n;
  logic              tx_hs;
  logic              accept;
  logic              load;
  logic [DATA_W-1:0] head_data;

  rx_state_t         rx_state;
  rx_state_t         rx_state_n;
  logic              rx_live;
  logic              rx_thresh;
  logic [15:0]       drop_cnt;
  logic              drop_inc;
  logic              in_hs;
  logic              in_head;
  logic              in_tail;
  logic [ID_W-1:0]   in_dest;
  logic [LEN_W-1:0]  in_len;

  ni_fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (core_tx_wr_en),
    .din   (core_tx_data),
    .pop   (tx_pop),
    .dout  (tx_fifo_data),
    .count (tx_count)
  );

  ni_fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .din   (link_in_flit[DATA_W-1:0]),
    .pop   (core_rx_rd_en),
    .dout  (rx_fifo_data),
    .count (rx_count)
  );

  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == CNT_W'(DEPTH));
  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == CNT_W'(DEPTH));

  assign accept = core_tx_start && !tx_busy;
  assign tx_hs  = tx_valid && link_out_ready;

  assign in_head = link_in_flit[DATA_W+1];
  assign in_tail = link_in_flit[DATA_W];
  assign in_dest = link_in_flit[LEN_W+ID_W +: ID_W];
  assign in_len  = link_in_flit[LEN_W-1:0];
  assign in_hs   = link_in_valid && link_in_ready;

  // head flit payload: pad, dest, source id, length in the LSBs
  always_comb begin
    head_data = '0;
    head_data[LEN_W-1:0] = core_tx_len;
    head_data[LEN_W +: ID_W] = NID;
    head_data[LEN_W+ID_W +: ID_W] = core_tx_dest;
  end

  // TX packetizer next state; body words are popped as they enter the flit register
  always_comb begin
    tx_state_n = tx_state;
    tx_flit_n  = tx_flit;
    tx_valid_n = tx_valid;
    tx_rem_n   = tx_rem;
    tx_busy_n  = tx_busy;
    tx_pop     = 1'b0;
    load       = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (accept) begin
          tx_state_n = TX_HEAD;
          tx_flit_n  = {1'b1, (core_tx_len == '0), head_data};
          tx_valid_n = 1'b1;
          tx_rem_n   = core_tx_len;
          tx_busy_n  = 1'b1;
        end
      end
      TX_HEAD: begin
        if (tx_hs) begin
          if (tx_flit[DATA_W]) begin
            tx_state_n = TX_IDLE;
            tx_valid_n = 1'b0;
            tx_busy_n  = 1'b0;
          end else begin
            tx_state_n = TX_BODY;
            tx_valid_n = 1'b0;
            load       = !tx_empty;
          end
        end
      end
      TX_BODY: begin
        if (tx_hs && tx_flit[DATA_W]) begin
          tx_state_n = TX_IDLE;
          tx_valid_n = 1'b0;
          tx_busy_n  = 1'b0;
        end else if (!tx_valid || tx_hs) begin
          tx_valid_n = 1'b0;
          load       = (tx_rem != '0) && !tx_empty;
        end
      end
      default: begin
        tx_state_n = TX_IDLE;
        tx_valid_n = 1'b0;
        tx_busy_n  = 1'b0;
      end
    endcase
    if (load) begin
      tx_flit_n  = {1'b0, (tx_rem == LEN_W'(1)), tx_fifo_data};
      tx_valid_n = 1'b1;
      tx_pop     = 1'b1;
      tx_rem_n   = tx_rem - LEN_W'(1);
    end
  end

  // TX state and registered link output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_flit  <= '0;
      tx_valid <= 1'b0;
      tx_rem   <= '0;
      tx_busy  <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_flit  <= tx_flit_n;
      tx_valid <= tx_valid_n;
      tx_rem   <= tx_rem_n;
      tx_busy  <= tx_busy_n;
    end
  end

  // RX link ready, held low until the first clock after reset
  always_comb begin
    link_in_ready = 1'b0;
    if (rx_live) begin
      case (rx_state)
        RX_WAIT:   link_in_ready = 1'b1;
        RX_ACCEPT: link_in_ready = !rx_full;
        RX_DROP:   link_in_ready = 1'b1;
        default:   link_in_ready = 1'b0;
      endcase
    end
  end

  // RX depacketizer: filter by destination, push payload, count drops
  always_comb begin
    rx_state_n = rx_state;
    rx_push    = 1'b0;
    drop_inc   = 1'b0;
    case (rx_state)
      RX_WAIT: begin
        if (in_hs) begin
          if (!in_head) begin
            drop_inc = 1'b1;
          end else if (in_dest != NID) begin
            drop_inc = 1'b1;
            if (in_len != '0) rx_state_n = RX_DROP;
          end else if (in_len != '0) begin
            rx_state_n = RX_ACCEPT;
          end
        end
      end
      RX_ACCEPT: begin
        if (in_hs) begin
          rx_push = 1'b1;
          if (in_tail) rx_state_n = RX_WAIT;
        end
      end
      RX_DROP: begin
        if (in_hs && in_tail) rx_state_n = RX_WAIT;
      end
      default: rx_state_n = RX_WAIT;
    endcase
  end

  // RX state, drop counter and threshold flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state  <= RX_WAIT;
      rx_live   <= 1'b0;
      drop_cnt  <= '0;
      rx_thresh <= 1'b0;
    end else begin
      rx_state  <= rx_state_n;
      rx_live   <= 1'b1;
      if (drop_inc && (drop_cnt != 16'hFFFF))
        drop_cnt <= drop_cnt + 16'd1;
      rx_thresh <= (rx_thresh_level != '0) &&
                   (rx_count >= rx_thresh_level);
    end
  end

  assign core_tx_full   = tx_full;
  assign core_tx_busy   = tx_busy;
  assign core_rx_data   = rx_empty ? '0 : rx_fifo_data;
  assign core_rx_empty  = rx_empty;
  assign core_rx_count  = rx_count;
  assign core_rx_thresh = rx_thresh;
  assign rx_drop_count  = drop_cnt;
  assign link_out_flit  = tx_flit;
  assign link_out_valid = tx_valid;

endmodule

// File: tb/tb_ni_packet_if.sv
// tb_ni_packet_if: table vectors and queue scoreboards
// for the ni_packet_if TX and RX paths.

module tb_ni_packet_if;

  logic        clk = 0;
  logic        reset = 1;
  logic [31:0] core_tx_data = 0;
  logic        core_tx_wr_en = 0;
  logic        core_tx_full;
  logic [7:0]  core_tx_dest = 0;
  logic [5:0]  core_tx_len = 0;
  logic        core_tx_start = 0;
  logic        core_tx_busy;
  logic [31:0] core_rx_data;
  logic        core_rx_rd_en = 0;
  logic        core_rx_empty;
  logic [6:0]  core_rx_count;
  logic [6:0]  rx_thresh_level = 7'd3;
  logic        core_rx_thresh;
  logic [15:0] rx_drop_count;
  logic [33:0] link_out_flit;
  logic        link_out_valid;
  logic        link_out_ready = 0;
  logic [33:0] link_in_flit = 0;
  logic        link_in_valid = 0;
  logic        link_in_ready;

  ni_packet_if dut (
    .clk             (clk),
    .reset           (reset),
    .core_tx_data    (core_tx_data),
    .core_tx_wr_en   (core_tx_wr_en),
    .core_tx_full    (core_tx_full),
    .core_tx_dest    (core_tx_dest),
    .core_tx_len     (core_tx_len),
    .core_tx_start   (core_tx_start),
    .core_tx_busy    (core_tx_busy),
    .core_rx_data    (core_rx_data),
    .core_rx_rd_en   (core_rx_rd_en),
    .core_rx_empty   (core_rx_empty),
    .core_rx_count   (core_rx_count),
    .rx_thresh_level (rx_thresh_level),
    .core_rx_thresh  (core_rx_thresh),
    .rx_drop_count   (rx_drop_count),
    .link_out_flit   (link_out_flit),
    .link_out_valid  (link_out_valid),
    .link_out_ready  (link_out_ready),
    .link_in_flit    (link_in_flit),
    .link_in_valid   (link_in_valid),
    .link_in_ready   (link_in_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  dest;
    logic [5:0]  len;
    int          npush;
    int          mode;
    logic [31:0] head_data;
    logic        tail;
  } tx_vec_t;

  typedef struct {
    logic        head;
    logic [7:0]  dest;
    logic [5:0]  len;
    logic        accept;
    int          pops;
    logic [15:0] drop_exp;
  } rx_vec_t;

  int checks = 0;
  int failures = 0;

  logic [33:0] exp_tx[$];
  logic [31:0] exp_rx[$];
  logic [31:0] pend[$];

  bit          tail_hs = 0;
  bit          prev_stall = 0;
  logic [33:0] prev_flit = 0;

  function automatic void chk(input string name,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // scoreboard monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("tx_hold_valid", link_out_valid, 1);
        chk("tx_hold_flit", link_out_flit, prev_flit);
      end
      if (link_out_valid && link_out_ready) begin
        if (exp_tx.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_unexpected: got %0h expected none",
                   link_out_flit);
        end else begin
          chk("tx_flit", link_out_flit, exp_tx.pop_front());
        end
        if (link_out_flit[32]) tail_hs = 1;
      end
      prev_stall = link_out_valid && !link_out_ready;
      prev_flit = link_out_flit;
      if (core_rx_rd_en && !core_rx_empty) begin
        if (exp_rx.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rx_unexpected: got %0h expected none",
                   core_rx_data);
        end else begin
          chk("rx_data", core_rx_data, exp_rx.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_flit(input logic [33:0] f);
    int n;
    n = 0;
    link_in_flit = f;
    link_in_valid = 1;
    while (!link_in_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("rx_ready_timeout", n, 0);
    tick();
    link_in_valid = 0;
  endtask

  task automatic set_ready(input int mode);
    case (mode)
      0: link_out_ready = 1;
      1: link_out_ready = ~link_out_ready;
      default: link_out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic run_tx(input tx_vec_t v);
    logic [31:0] w;
    int n;
    for (int i = 0; i < v.npush; i++) begin
      w = $urandom;
      core_tx_data = w;
      core_tx_wr_en = 1;
      pend.push_back(w);
      tick();
    end
    core_tx_wr_en = 0;
    exp_tx.push_back({1'b1, v.tail, v.head_data});
    for (int i = 0; i < int'(v.len); i++)
      exp_tx.push_back({1'b0, (i == int'(v.len) - 1), pend.pop_front()});
    core_tx_dest = v.dest;
    core_tx_len = v.len;
    core_tx_start = 1;
    link_out_ready = (v.mode == 0);
    tick();
    chk("tx_busy_rise", core_tx_busy, 1);
    chk("tx_head_valid", link_out_valid, 1);
    core_tx_dest = 8'hAA;
    core_tx_len = 6'd1;
    tail_hs = 0;
    n = 0;
    while (!tail_hs && n < 300) begin
      set_ready(v.mode);
      tick();
      core_tx_start = 0;
      n++;
    end
    core_tx_start = 0;
    if (n >= 300) chk("tx_timeout", n, 0);
    chk("tx_busy_fall", core_tx_busy, 0);
    link_out_ready = 0;
    repeat (3) tick();
    chk("tx_idle_valid", link_out_valid, 0);
    chk("tx_queue_left", exp_tx.size(), 0);
  endtask

  task automatic run_rx(input rx_vec_t v);
    logic [31:0] hd;
    logic [31:0] w;
    int sz;
    if (v.head) begin
      hd = {10'b0, v.dest, 8'h3C, v.len};
      send_flit({1'b1, (v.len == 0), hd});
    end else begin
      send_flit({2'b00, 32'($urandom)});
    end
    for (int i = 0; i < int'(v.len); i++) begin
      w = $urandom;
      if (v.accept) exp_rx.push_back(w);
      send_flit({1'b0, (i == int'(v.len) - 1), w});
    end
    repeat (2) tick();
    sz = exp_rx.size();
    chk("rx_drop", rx_drop_count, v.drop_exp);
    chk("rx_count", core_rx_count, sz);
    chk("rx_thresh", core_rx_thresh,
        (rx_thresh_level != 0) && (sz >= int'(rx_thresh_level)));
    if (v.pops > 0) begin
      for (int i = 0; i < v.pops; i++) begin
        core_rx_rd_en = 1;
        tick();
      end
      core_rx_rd_en = 0;
      repeat (2) tick();
      sz = exp_rx.size();
      chk("rx_count_pop", core_rx_count, sz);
      chk("rx_thresh_pop", core_rx_thresh,
          (rx_thresh_level != 0) && (sz >= int'(rx_thresh_level)));
    end
  endtask

  tx_vec_t tx_tab[4];
  rx_vec_t rx_tab[6];
  tx_vec_t tx_post;
  rx_vec_t rx_post;
  rx_vec_t rx_fill;
  logic [31:0] w2;

  initial begin
    tx_tab[0] = '{8'd5,    6'd3, 3, 0, 32'h0001_4003, 1'b0};
    tx_tab[1] = '{8'd2,    6'd0, 1, 0, 32'h0000_8000, 1'b1};
    tx_tab[2] = '{8'h11,   6'd1, 0, 1, 32'h0004_4001, 1'b0};
    tx_tab[3] = '{8'hFF,   6'd5, 5, 2, 32'h003F_C005, 1'b0};
    rx_tab[0] = '{1'b1, 8'd0, 6'd4, 1'b1, 2, 16'd0};
    rx_tab[1] = '{1'b1, 8'd7, 6'd2, 1'b0, 0, 16'd1};
    rx_tab[2] = '{1'b1, 8'd0, 6'd2, 1'b1, 0, 16'd1};
    rx_tab[3] = '{1'b1, 8'd0, 6'd0, 1'b0, 0, 16'd1};
    rx_tab[4] = '{1'b0, 8'd0, 6'd0, 1'b0, 0, 16'd2};
    rx_tab[5] = '{1'b1, 8'd0, 6'd1, 1'b1, 5, 16'd2};
    rx_fill   = '{1'b1, 8'd0, 6'd63, 1'b1, 0, 16'd2};
    rx_post   = '{1'b1, 8'd0, 6'd1, 1'b1, 1, 16'd0};
    tx_post   = '{8'd3, 6'd2, 2, 0, 32'h0000_C002, 1'b0};

    repeat (3) tick();
    chk("rst_rx_empty", core_rx_empty, 1);
    chk("rst_rx_count", core_rx_count, 0);
    chk("rst_tx_busy", core_tx_busy, 0);
    chk("rst_tx_full", core_tx_full, 0);
    chk("rst_out_valid", link_out_valid, 0);
    chk("rst_out_flit", link_out_flit, 0);
    chk("rst_in_ready", link_in_ready, 0);
    chk("rst_drop", rx_drop_count, 0);
    chk("rst_thresh", core_rx_thresh, 0);
    chk("rst_rx_data", core_rx_data, 0);
    reset = 0;
    tick();
    chk("in_ready_live", link_in_ready, 1);

    for (int i = 0; i < 4; i++) run_tx(tx_tab[i]);
    for (int i = 0; i < 6; i++) run_rx(rx_tab[i]);

    rx_thresh_level = 0;
    run_rx(rx_fill);
    send_flit({1'b1, 1'b0, 10'b0, 8'd0, 8'h3C, 6'd2});
    w2 = $urandom;
    exp_rx.push_back(w2);
    send_flit({2'b00, w2});
    tick();
    chk("fill_count", core_rx_count, 64);
    w2 = $urandom;
    exp_rx.push_back(w2);
    link_in_flit = {2'b01, w2};
    link_in_valid = 1;
    repeat (3) tick();
    chk("full_ready", link_in_ready, 0);
    chk("full_count", core_rx_count, 64);
    chk("thresh_off", core_rx_thresh, 0);
    core_rx_rd_en = 1;
    tick();
    core_rx_rd_en = 0;
    chk("pop_ready", link_in_ready, 1);
    tick();
    link_in_valid = 0;
    chk("refill_count", core_rx_count, 64);

    send_flit({1'b1, 1'b0, 10'b0, 8'd0, 8'h3C, 6'd3});
    link_in_flit = {2'b00, 32'h1234_5678};
    link_in_valid = 1;
    for (int i = 0; i < 2; i++) begin
      core_tx_data = $urandom;
      core_tx_wr_en = 1;
      tick();
    end
    core_tx_wr_en = 0;
    core_tx_dest = 8'd9;
    core_tx_len = 6'd2;
    core_tx_start = 1;
    tick();
    core_tx_start = 0;
    chk("pre_rst_busy", core_tx_busy, 1);
    tick();
    @(posedge clk);
    #3;
    reset = 1;
    link_in_valid = 0;
    #1;
    chk("mid_rst_busy", core_tx_busy, 0);
    chk("mid_rst_valid", link_out_valid, 0);
    chk("mid_rst_count", core_rx_count, 0);
    chk("mid_rst_empty", core_rx_empty, 1);
    chk("mid_rst_drop", rx_drop_count, 0);
    chk("mid_rst_ready", link_in_ready, 0);
    exp_rx.delete();
    exp_tx.delete();
    pend.delete();
    repeat (2) tick();
    reset = 0;
    rx_thresh_level = 3;
    tick();
    chk("post_rst_ready", link_in_ready, 1);
    run_rx(rx_post);
    run_tx(tx_post);
    chk("final_empty", core_rx_empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
